fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_if.sv | 11 +
 rtl/inst_hold_buf.sv | 53 +++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and hold-buffer state encoding for the fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_HELD  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory bus between the fetch stage (master) and a synchronous memory (slave).
interface fetch_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);

endinterface

// File: rtl/inst_hold_buf.sv
// Captures the decode-stage instruction word while decode is stalled, since the
// synchronous memory output moves on once its address advances.
module inst_hold_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] data_i,
    output logic            held_o,
    output logic [XLEN-1:0] data_o
);

    hold_state_e     state_q, state_d;
    logic [XLEN-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HOLD_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (flush_i) begin
            state_d = HOLD_EMPTY;
            data_d  = '0;
        end else begin
            case (state_q)
                HOLD_EMPTY: begin
                    if (stall_i) begin
                        state_d = HOLD_HELD;
                        data_d  = data_i;
                    end
                end
                HOLD_HELD: begin
                    if (!stall_i) state_d = HOLD_EMPTY;
                end
                default: state_d = HOLD_EMPTY;
            endcase
        end
    end

    assign held_o = (state_q == HOLD_HELD);
    assign data_o = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, IF/ID pipeline register and decode hold buffer.
// Optional statistics counters are enabled with FETCH_STAT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] npc,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    fetch_if.master         imem,
    output logic [XLEN-1:0] PC_IF,
    output logic [XLEN-1:0] PC_plus4,
    output logic [XLEN-1:0] PC_ID,
    output logic [XLEN-1:0] inst_ID,
    output logic            valid_ID
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     flush_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    logic [XLEN-1:0] pc_if_q, pc_if_d;
    logic [XLEN-1:0] pc_id_q;
    logic            valid_id_q;
    logic            held;
    logic [XLEN-1:0] held_data;

    // Masking keeps every npc bit in use while forcing word alignment.
    assign pc_if_d = npc & ~32'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_if_q <= RESET_PC;
        end else if (!stallF) begin
            pc_if_q <= pc_if_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_id_q    <= '0;
            valid_id_q <= 1'b0;
        end else if (flushD) begin
            valid_id_q <= 1'b0;
        end else if (!stallD) begin
            pc_id_q    <= pc_if_q;
            valid_id_q <= !stallF;
        end
    end

    inst_hold_buf u_hold (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stallD),
        .flush_i (flushD),
        .data_i  (imem.imem_rdata),
        .held_o  (held),
        .data_o  (held_data)
    );

    assign imem.imem_addr = pc_if_q;
    assign PC_IF          = pc_if_q;
    assign PC_plus4       = pc_if_q + 32'd4;
    assign PC_ID          = pc_id_q;
    assign valid_ID       = valid_id_q;
    // Invalid decode slots (reset, flush, bubble) always present a NOP.
    assign inst_ID        = !valid_id_q ? NOP_INST :
                            held        ? held_data : imem.imem_rdata;

`ifdef FETCH_STAT_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (!flushD && !stallD && !stallF && fetch_cnt_q != '1)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (flushD && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 32'd1;
            if (stallF && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a synchronous instruction memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF, stallD, flushD;
    logic        npc_sel;
    logic [31:0] npc_ovr, npc;
    logic [31:0] PC_IF, PC_plus4, PC_ID, inst_ID;
    logic        valid_ID;
`ifdef FETCH_STAT_EN
    logic [31:0] fetch_cnt, flush_cnt, stall_cnt;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    fetch_if imem ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .npc      (npc),
        .stallF   (stallF),
        .stallD   (stallD),
        .flushD   (flushD),
        .imem     (imem.master),
        .PC_IF    (PC_IF),
        .PC_plus4 (PC_plus4),
        .PC_ID    (PC_ID),
        .inst_ID  (inst_ID),
        .valid_ID (valid_ID)
`ifdef FETCH_STAT_EN
        ,
        .fetch_cnt(fetch_cnt),
        .flush_cnt(flush_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    always @(posedge clk) imem.imem_rdata <= memf(imem.imem_addr);

    assign npc = npc_sel ? PC_plus4 : npc_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        npc_sel = 1'b1; npc_ovr = 32'h0;
        tick(); tick();
        check("rst_pc_if", PC_IF, 32'h0);
        check("rst_pc_id", PC_ID, 32'h0);
        check("rst_valid", {31'h0, valid_ID}, 32'h0);
        check("rst_inst", inst_ID, NOP_INST);
        check("rst_hold", 32'(dut.u_hold.state_q), 32'(HOLD_EMPTY));
        rst = 1'b0;
        check("seq_pc_if0", PC_IF, 32'h0);
        check("seq_plus4", PC_plus4, 32'h4);

        tick();
        check("seq_pc_if4", PC_IF, 32'h4);
        check("seq_pc_id0", PC_ID, 32'h0);
        check("seq_valid0", {31'h0, valid_ID}, 32'h1);
        check("seq_inst0", inst_ID, memf(32'h0));
        tick();
        check("seq_pc_if8", PC_IF, 32'h8);
        check("seq_addr8", imem.imem_addr, 32'h8);
        check("seq_pc_id4", PC_ID, 32'h4);
        check("seq_inst4", inst_ID, memf(32'h4));
        tick(); tick(); tick();
        check("pre_stall_id", PC_ID, 32'h10);
        check("pre_stall_if", PC_IF, 32'h14);

        // three cycles of decode+fetch stall
        stallD = 1'b1; stallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_inst", inst_ID, memf(32'h10));
            check("stall_pc_if", PC_IF, 32'h14);
            check("stall_hold", 32'(dut.u_hold.state_q), 32'(HOLD_HELD));
        end
        stallD = 1'b0; stallF = 1'b0;
        check("unstall_inst", inst_ID, memf(32'h10));
        tick();
        check("after_stall_id", PC_ID, 32'h14);
        check("after_stall_inst", inst_ID, memf(32'h14));
        check("after_stall_hold", 32'(dut.u_hold.state_q), 32'(HOLD_EMPTY));

        // mispredict flush to 0x200
        flushD = 1'b1; npc_sel = 1'b0; npc_ovr = 32'h200;
        tick();
        flushD = 1'b0; npc_sel = 1'b1;
        check("flush_valid", {31'h0, valid_ID}, 32'h0);
        check("flush_inst", inst_ID, NOP_INST);
        check("flush_pc_if", PC_IF, 32'h200);
        tick();
        check("post_flush_id", PC_ID, 32'h200);
        check("post_flush_valid", {31'h0, valid_ID}, 32'h1);
        check("post_flush_inst", inst_ID, memf(32'h200));

        // flush and stallD together while HELD
        stallD = 1'b1; stallF = 1'b1;
        tick();
        check("held_state", 32'(dut.u_hold.state_q), 32'(HOLD_HELD));
        check("held_inst", inst_ID, memf(32'h200));
        flushD = 1'b1;
        tick();
        check("fs_hold", 32'(dut.u_hold.state_q), 32'(HOLD_EMPTY));
        check("fs_valid", {31'h0, valid_ID}, 32'h0);
        check("fs_inst", inst_ID, NOP_INST);
        check("fs_pc_if", PC_IF, 32'h204);
        flushD = 1'b0; stallD = 1'b0; stallF = 1'b0;
        tick();
        check("fs_after_id", PC_ID, 32'h204);
        check("fs_after_inst", inst_ID, memf(32'h204));

        // stallF alone inserts a bubble
        stallF = 1'b1;
        tick();
        stallF = 1'b0;
        check("bubble_valid", {31'h0, valid_ID}, 32'h0);
        check("bubble_inst", inst_ID, NOP_INST);
        check("bubble_pc_if", PC_IF, 32'h208);
        tick();
        check("bubble_after_id", PC_ID, 32'h208);
        check("bubble_after_inst", inst_ID, memf(32'h208));

        // PC wrap and alignment
        npc_sel = 1'b0; npc_ovr = 32'hFFFF_FFFC;
        tick();
        check("wrap_pc_if", PC_IF, 32'hFFFF_FFFC);
        check("wrap_plus4", PC_plus4, 32'h0);
        npc_ovr = 32'h103;
        tick();
        check("align_pc_if", PC_IF, 32'h100);
        check("align_addr", imem.imem_addr, 32'h100);

        // reset in the middle of a stall
        npc_sel = 1'b1; stallD = 1'b1; stallF = 1'b1;
        tick();
        check("mid_held", 32'(dut.u_hold.state_q), 32'(HOLD_HELD));
        rst = 1'b1;
        #1;
        check("mid_rst_pc_if", PC_IF, 32'h0);
        check("mid_rst_hold", 32'(dut.u_hold.state_q), 32'(HOLD_EMPTY));
        check("mid_rst_valid", {31'h0, valid_ID}, 32'h0);
        check("mid_rst_inst", inst_ID, NOP_INST);
        tick();
        rst = 1'b0; stallD = 1'b0; stallF = 1'b0;
        tick();
        check("rel_pc_id", PC_ID, 32'h0);
        check("rel_valid", {31'h0, valid_ID}, 32'h1);
        check("rel_inst", inst_ID, memf(32'h0));
        check("rel_pc_if", PC_IF, 32'h4);

`ifdef FETCH_STAT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt_rst_fetch", fetch_cnt, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        stallF = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        stallF = 1'b0; flushD = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        flushD = 1'b0;
        check("cnt_fetch", fetch_cnt, 32'd5);
        check("cnt_flush", flush_cnt, 32'd2);
        check("cnt_stall", stall_cnt, 32'd3);
        rst = 1'b1;
        #1;
        check("cnt_clr_fetch", fetch_cnt, 32'h0);
        check("cnt_clr_flush", flush_cnt, 32'h0);
        check("cnt_clr_stall", stall_cnt, 32'h0);
        rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
